insn_enc: RTL and testbench

INSN_ENC -- requirements
Module: insn_enc

---
 rtl/insn_enc_pkg.sv | 50 +++++
 rtl/insn_fifo.sv | 74 +++++++
 rtl/insn_enc.sv | 104 ++++++++++
 tb/tb_insn_enc.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/insn_enc_pkg.sv
// Shared MIPS subset definitions: mnemonic codes, opcode/funct constants and the
// instruction encoder used by insn_enc and the control decoder bench.
package insn_enc_pkg;

    typedef enum logic [2:0] {
        MN_ADDU = 3'd0,
        MN_SUBU = 3'd1,
        MN_ORI  = 3'd2,
        MN_LW   = 3'd3,
        MN_SW   = 3'd4,
        MN_BEQ  = 3'd5,
        MN_LUI  = 3'd6,
        MN_BAD  = 3'd7
    } mnem_e;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

    // Unsupported mnemonics encode as nop; the caller decides whether they are queued.
    function automatic logic [31:0] encode_insn(
        input mnem_e       mn,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [15:0] imm
    );
        logic [31:0] word;
        word = NOP_WORD;
        case (mn)
            MN_ADDU: word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_ADDU};
            MN_SUBU: word = {OP_RTYPE, rs, rt, rd, 5'd0, FUNCT_SUBU};
            MN_ORI:  word = {OP_ORI, rs, rt, imm};
            MN_LW:   word = {OP_LW,  rs, rt, imm};
            MN_SW:   word = {OP_SW,  rs, rt, imm};
            MN_BEQ:  word = {OP_BEQ, rs, rt, imm};
            MN_LUI:  word = {OP_LUI, 5'd0, rt, imm};
            default: word = NOP_WORD;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/insn_fifo.sv
// Synchronous FIFO holding encoded instruction words; head word is visible
// combinationally so a word written at one edge is presented right after it.
module insn_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    import insn_enc_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!rst && do_push && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= wdata;
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/insn_enc.sv
// MIPS instruction encoder front end: encodes one request per accept into a
// FIFO and tracks the instruction-memory address of the head word.
// Optional macro INSN_ENC_ERR_EN: adds sticky err output and drops mnemonic 7.
module insn_enc
    import insn_enc_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_mn,
    input  logic [4:0]              in_rs,
    input  logic [4:0]              in_rt,
    input  logic [4:0]              in_rd,
    input  logic [15:0]             in_imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_insn,
    output logic [31:0]             out_addr,
`ifdef INSN_ENC_ERR_EN
    output logic                    err,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    logic [31:0] enc_word;
    logic        accept;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] addr_q, addr_d;

    always_comb begin
        enc_word = encode_insn(mnem_e'(in_mn), in_rs, in_rt, in_rd, in_imm);
    end

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign accept    = in_valid && in_ready;
    assign fifo_pop  = out_valid && out_ready;

`ifdef INSN_ENC_ERR_EN
    logic err_q, err_d;

    // Unsupported requests are consumed but never reach the FIFO.
    assign fifo_push = accept && (mnem_e'(in_mn) != MN_BAD);

    always_comb begin
        err_d = err_q;
        if (accept && (mnem_e'(in_mn) == MN_BAD)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign fifo_push = accept;
`endif

    always_comb begin
        addr_d = addr_q;
        if (fifo_pop) begin
            addr_d = addr_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign out_addr = addr_q;

    insn_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (enc_word),
        .rdata (out_insn),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_insn_enc.sv
// Randomized and directed bench for insn_enc against a queue-based reference model.
module tb_insn_enc;

    localparam int DEPTH = 4;
    localparam logic [31:0] BASE = 32'h0000_3000;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [2:0]              in_mn = '0;
    logic [4:0]              in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0]             in_imm = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [31:0]             out_insn;
    logic [31:0]             out_addr;
    logic [$clog2(DEPTH):0]  count;
`ifdef INSN_ENC_ERR_EN
    logic                    err;
`endif

    insn_enc #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mn     (in_mn),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_insn  (out_insn),
        .out_addr  (out_addr),
`ifdef INSN_ENC_ERR_EN
        .err       (err),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_q [$];
    logic [31:0] model_addr = BASE;
    bit          model_err  = 1'b0;
    bit          chk_en     = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Field-level reference encoding straight from the MIPS instruction formats.
    function automatic logic [31:0] ref_enc(input logic [2:0] mn, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] rd,
                                            input logic [15:0] imm);
        logic [31:0] w;
        case (mn)
            3'd0: w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'h21;
            3'd1: w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'h23;
            3'd2: w = (32'h0D << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            3'd3: w = (32'h23 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            3'd4: w = (32'h2B << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            3'd5: w = (32'h04 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            3'd6: w = (32'h0F << 26) | (32'(rt) << 16) | 32'(imm);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // One clock: drive inputs, compare DUT state with the model, then advance both.
    task automatic cycle(input bit r, input bit v, input logic [2:0] mn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input bit ordy);
        bit acc, pp;
        rst = r; in_valid = v; in_mn = mn; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; out_ready = ordy;
        #1;
        if (chk_en) begin
            check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            check("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
            check("count",     32'(count),     32'(model_q.size()));
            if (model_q.size() != 0) begin
                check("out_insn", out_insn, model_q[0]);
                check("out_addr", out_addr, model_addr);
            end
`ifdef INSN_ENC_ERR_EN
            check("err", 32'(err), 32'(model_err));
`endif
        end
        acc = v && (model_q.size() != DEPTH);
        pp  = ordy && (model_q.size() != 0);
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_addr = BASE;
            model_err  = 1'b0;
        end else begin
            if (pp) begin
                void'(model_q.pop_front());
                model_addr = model_addr + 32'd4;
            end
            if (acc) begin
`ifdef INSN_ENC_ERR_EN
                if (mn == 3'd7) model_err = 1'b1;
                else model_q.push_back(ref_enc(mn, rs, rt, rd, imm));
`else
                model_q.push_back(ref_enc(mn, rs, rt, rd, imm));
`endif
            end
        end
        @(negedge clk);
        chk_en = 1'b1;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, ordy);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", out_addr, BASE);
        $display("reset done");

        // addu rs=1 rt=2 rd=3 (imm must be ignored)
        cycle(1'b0, 1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 16'hBEEF, 1'b0);
        #1;
        check("addu_insn", out_insn, 32'h00221821);
        check("addu_addr", out_addr, 32'h00003000);
        $display("addu -> %08h @ %08h", out_insn, out_addr);
        idle(1'b1);

        // ori then lui (rs forced to 0, rd ignored)
        do_reset();
        cycle(1'b0, 1'b1, 3'd2, 5'd0, 5'd8, 5'd31, 16'h1234, 1'b0);
        cycle(1'b0, 1'b1, 3'd6, 5'd5, 5'd1, 5'd9, 16'hFFFF, 1'b0);
        #1;
        check("ori_insn", out_insn, 32'h34081234);
        check("ori_addr", out_addr, 32'h00003000);
        $display("ori -> %08h @ %08h", out_insn, out_addr);
        idle(1'b1);
        #1;
        check("lui_insn", out_insn, 32'h3C01FFFF);
        check("lui_addr", out_addr, 32'h00003004);
        $display("lui -> %08h @ %08h", out_insn, out_addr);
        idle(1'b1);

        // fill, hold fifth, pop while full, then push+pop at constant count
        do_reset();
        cycle(1'b0, 1'b1, 3'd4, 5'd0, 5'd2, 5'd0, 16'h0004, 1'b0);
        cycle(1'b0, 1'b1, 3'd5, 5'd1, 5'd2, 5'd0, 16'hFFFE, 1'b0);
        cycle(1'b0, 1'b1, 3'd0, 5'd4, 5'd5, 5'd6, 16'h0000, 1'b0);
        cycle(1'b0, 1'b1, 3'd1, 5'd7, 5'd8, 5'd9, 16'h0000, 1'b0);
        #1;
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        $display("full: count=%0d in_ready=%0d", count, in_ready);
        cycle(1'b0, 1'b1, 3'd3, 5'd3, 5'd3, 5'd0, 16'h0010, 1'b0);
        #1;
        check("held_count", 32'(count), 32'd4);
        check("held_head", out_insn, 32'hAC020004);
        cycle(1'b0, 1'b1, 3'd3, 5'd3, 5'd3, 5'd0, 16'h0010, 1'b1);
        #1;
        check("popfull_ready", 32'(in_ready), 32'd1);
        check("popfull_count", 32'(count), 32'd3);
        check("order_beq", out_insn, 32'h1022FFFE);
        $display("pop at full: count=%0d head=%08h", count, out_insn);
        cycle(1'b0, 1'b1, 3'd3, 5'd3, 5'd3, 5'd0, 16'h0010, 1'b1);
        #1;
        check("pushpop_count", 32'(count), 32'd3);
        check("pushpop_addr", out_addr, 32'h00003008);

        // reset with words queued, inputs active on the reset edge
        cycle(1'b1, 1'b1, 3'd0, 5'd1, 5'd1, 5'd1, 16'h0, 1'b1);
        #1;
        check("rstq_valid", 32'(out_valid), 32'd0);
        check("rstq_count", 32'(count), 32'd0);
        cycle(1'b0, 1'b1, 3'd1, 5'd2, 5'd3, 5'd4, 16'h0, 1'b0);
        #1;
        check("rstq_addr", out_addr, 32'h00003000);
        $display("after reset: count=%0d addr=%08h", count, out_addr);
        idle(1'b1);

        // unsupported mnemonic
        do_reset();
        cycle(1'b0, 1'b1, 3'd7, 5'd9, 5'd9, 5'd9, 16'h5555, 1'b0);
        #1;
`ifdef INSN_ENC_ERR_EN
        check("bad_err", 32'(err), 32'd1);
        check("bad_count", 32'(count), 32'd0);
`else
        check("bad_count", 32'(count), 32'd1);
        check("bad_insn", out_insn, 32'h0);
`endif
        $display("mn=7: count=%0d insn=%08h", count, out_insn);

        // randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
                  3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                  16'($urandom), ($urandom_range(0, 2) == 0));
        end
        // drain to observe every remaining word
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
        $display("random phase done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
